// File: rtl/fp_mul_arbiter.sv
`timescale 1ns/1ps
// fp_mul_arbiter: round-robin sharing of one FP multiplier among N_REQ
// requesters. Captures operands at accept, pulses start, waits for done
// (or a watchdog expiry) and returns product plus sticky flags.
module fp_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid_i,
  output logic [N_REQ-1:0]    req_ready_o,
  input  logic [32*N_REQ-1:0] req_a_i,
  input  logic [32*N_REQ-1:0] req_b_i,
  output logic [N_REQ-1:0]    rsp_valid_o,
  output logic [31:0]         rsp_product_o,
  output logic [4:0]          rsp_flags_o,
  output logic                busy_o,
  output logic                mul_start_o,
  output logic [31:0]         mul_a_o,
  output logic [31:0]         mul_b_o,
  input  logic [31:0]         mul_product_i,
  input  logic                mul_done_i,
  input  logic                mul_nan_i,
  input  logic                mul_inf_i,
  input  logic                mul_ovf_i,
  input  logic                mul_unf_i
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW:0]   N_REQ_W  = (PW+1)'(N_REQ);
  localparam logic [PW-1:0] LAST_REQ = PW'(N_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   gnt_q, gnt_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [31:0]     product_q, product_d;
  logic [4:0]      flags_q, flags_d;
  logic [3:0]      acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [PW:0]     scan_sum;
  logic [31:0]     req_a_arr [N_REQ];
  logic [31:0]     req_b_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign req_a_arr[k] = req_a_i[32*k +: 32];
    assign req_b_arr[k] = req_b_i[32*k +: 32];
  end

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_sum  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (scan_sum >= N_REQ_W) scan_sum = scan_sum - N_REQ_W;
      if (!gnt_found && req_valid_i[scan_sum[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_sum[PW-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; done takes priority over watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (mul_done_i || (cnt_q == CNT_LAST)) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: operand capture, flag accumulation, watchdog, pointer.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    flags_d   = flags_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          gnt_d = gnt_idx;
          a_d   = req_a_arr[gnt_idx];
          b_d   = req_b_arr[gnt_idx];
          acc_d = '0;
        end
      end
      S_ISSUE: cnt_d = '0;
      S_WAIT: begin
        acc_d = acc_q | {mul_unf_i, mul_ovf_i, mul_inf_i, mul_nan_i};
        if (mul_done_i) begin
          product_d = mul_product_i;
          flags_d   = {1'b0, acc_d};
        end else if (cnt_q == CNT_LAST) begin
          product_d = '0;
          flags_d   = {1'b1, acc_d};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: rr_ptr_d = (gnt_q == LAST_REQ) ? '0 : gnt_q + 1'b1;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      flags_q   <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      flags_q   <= flags_d;
    end
  end

  // Outputs decoded from state. The accept strobe is combinational from IDLE,
  // which is also the reset state, so it is gated by rst_n to stay 0 in reset.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    mul_start_o = 1'b0;
    busy_o      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (gnt_found && rst_n) req_ready_o[gnt_idx] = 1'b1;
      S_ISSUE: mul_start_o = 1'b1;
      S_RESP:  rsp_valid_o[gnt_q] = 1'b1;
      default: ;
    endcase
  end

  assign mul_a_o       = a_q;
  assign mul_b_o       = b_q;
  assign rsp_product_o = product_q;
  assign rsp_flags_o   = flags_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for fp_mul_arbiter with a scripted multiplier stub.
module tb_fp_mul_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready_o;
  logic [32*N-1:0] req_a, req_b;
  logic [N-1:0]    rsp_valid_o;
  logic [31:0]     rsp_product_o;
  logic [4:0]      rsp_flags_o;
  logic            busy_o, mul_start_o;
  logic [31:0]     mul_a_o, mul_b_o, mul_product_i;
  logic            mul_done_i, mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i;

  fp_mul_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid_o), .rsp_product_o(rsp_product_o), .rsp_flags_o(rsp_flags_o),
    .busy_o(busy_o), .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_product_i(mul_product_i), .mul_done_i(mul_done_i),
    .mul_nan_i(mul_nan_i), .mul_inf_i(mul_inf_i), .mul_ovf_i(mul_ovf_i), .mul_unf_i(mul_unf_i)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin @(posedge clk); cyc = cyc + 1; end

  typedef struct {
    logic [N-1:0] vld;
    logic [31:0]  prod;
    logic [4:0]   flags;
    int           cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Stub configuration, set by the stimulus at accept time.
  int          st_lat = 3, st_foff = 0;
  logic [31:0] st_prod = '0;
  logic [3:0]  st_fl = '0;   // {unf, ovf, inf, nan}

  // Multiplier stub: done st_lat cycles after the start cycle (0 = never).
  initial begin
    mul_done_i = 1'b0; mul_product_i = '0;
    {mul_unf_i, mul_ovf_i, mul_inf_i, mul_nan_i} = 4'b0;
    forever begin
      @(negedge clk);
      if (mul_start_o && st_lat > 0) begin
        for (int j = 1; j <= st_lat; j++) begin
          @(posedge clk); #1;
          mul_done_i    = (j == st_lat);
          mul_product_i = (j == st_lat) ? st_prod : 32'h0;
          {mul_unf_i, mul_ovf_i, mul_inf_i, mul_nan_i} = (j == st_foff) ? st_fl : 4'b0;
        end
        @(posedge clk); #1;
        mul_done_i = 1'b0; mul_product_i = '0;
        {mul_unf_i, mul_ovf_i, mul_inf_i, mul_nan_i} = 4'b0;
      end
    end
  end

  // Response monitor.
  initial forever begin
    @(negedge clk);
    if (rsp_valid_o !== '0) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got valid %b expected none", rsp_valid_o);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid_o), 32'(mon_e.vld));
        chk("rsp_product", rsp_product_o, mon_e.prod);
        chk("rsp_flags", 32'(rsp_flags_o), 32'(mon_e.flags));
        chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Wait for a grant to requester k, configure the stub, queue the expectation.
  task automatic serve(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] stub_prod, input logic [3:0] stub_fl,
                       input int lat, input int foff,
                       input logic [31:0] exp_prod, input logic [4:0] exp_flags,
                       input int exp_delay, input bit push, input bit drop);
    bit got = 0;
    logic [N-1:0] want;
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready_o != '0) begin got = 1; break; end
    end
    want = '0; want[k] = 1'b1;
    chk("req_ready", 32'(req_ready_o), 32'(want));
    if (!got) return;
    st_lat = lat; st_foff = foff; st_prod = stub_prod; st_fl = stub_fl;
    if (push) begin
      e.vld = want; e.prod = exp_prod; e.flags = exp_flags; e.cyc = cyc + exp_delay;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if (drop) begin
      req_valid[k] = 1'b0;
      req_a[32*k +: 32] = 32'hDEADBEEF;
      req_b[32*k +: 32] = 32'hBAADF00D;
    end
    @(negedge clk);
    chk("mul_start", 32'(mul_start_o), 32'd1);
    chk("mul_a", mul_a_o, a);
    chk("mul_b", mul_b_o, b);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!busy_o) begin ok = 1; break; end
    end
    chk("idle_reached", 32'(ok), 32'd1);
  endtask

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b);
    req_a[32*k +: 32] = a;
    req_b[32*k +: 32] = b;
    req_valid[k] = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready_o), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, "_product"}, rsp_product_o, 32'd0);
    chk({tag, "_flags"}, 32'(rsp_flags_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_start"}, 32'(mul_start_o), 32'd0);
    chk({tag, "_mul_a"}, mul_a_o, 32'd0);
    chk({tag, "_mul_b"}, mul_b_o, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0;
    // Requesters 0 and 2 already valid during reset.
    set_req(0, 32'h40000000, 32'h40400000);
    set_req(2, 32'h3F800000, 32'hC0000000);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1; rst_n = 1'b1;

    // Round robin 0,2,0,2 with continuous requests.
    serve(0, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0, 3, 0, 32'h40C00000, 5'b00000, 5, 1, 0);
    serve(2, 32'h3F800000, 32'hC0000000, 32'hC0000000, 4'b0, 3, 0, 32'hC0000000, 5'b00000, 5, 1, 0);
    serve(0, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0, 3, 0, 32'h40C00000, 5'b00000, 5, 1, 1);
    serve(2, 32'h3F800000, 32'hC0000000, 32'hC0000000, 4'b0, 3, 0, 32'hC0000000, 5'b00000, 5, 1, 1);
    wait_idle();

    // Single requester basic product; operands scrambled after accept.
    @(posedge clk); #1; set_req(0, 32'h40000000, 32'h40400000);
    serve(0, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0, 3, 0, 32'h40C00000, 5'b00000, 5, 1, 1);
    wait_idle();

    // NaN pulse one cycle after start.
    @(posedge clk); #1; set_req(1, 32'h7FC00000, 32'h3F800000);
    serve(1, 32'h7FC00000, 32'h3F800000, 32'h00000000, 4'b0001, 3, 1, 32'h00000000, 5'b00001, 5, 1, 1);
    wait_idle();

    // Overflow pulse coincident with done.
    @(posedge clk); #1; set_req(3, 32'h7F000000, 32'h7F000000);
    serve(3, 32'h7F000000, 32'h7F000000, 32'h7FFFFFFF, 4'b0100, 3, 3, 32'h7FFFFFFF, 5'b00100, 5, 1, 1);
    wait_idle();

    // Watchdog: stub never completes; response 16 WAIT cycles after ISSUE.
    @(posedge clk); #1; set_req(2, 32'h40000000, 32'h40000000);
    serve(2, 32'h40000000, 32'h40000000, 32'h0, 4'b0, 0, 0, 32'h00000000, 5'b10000, TO + 2, 1, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid_o != '0) begin seen = 1; break; end
    end
    chk("to_rsp_seen", 32'(seen), 32'd1);
    chk("to_busy_in_resp", 32'(busy_o), 32'd1);
    @(negedge clk);
    chk("to_busy_after", 32'(busy_o), 32'd0);

    // Normal operation after timeout, longer latency.
    @(posedge clk); #1; set_req(1, 32'h3F800000, 32'h3F800000);
    serve(1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0, 5, 0, 32'h3F800000, 5'b00000, 7, 1, 1);
    wait_idle();

    // Reset during WAIT: no response; late done lands in IDLE and is ignored.
    @(posedge clk); #1; set_req(2, 32'h40800000, 32'h40800000);
    serve(2, 32'h40800000, 32'h40800000, 32'h41800000, 4'b0, 12, 0, 32'h0, 5'b0, 0, 0, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", 32'(busy_o), 32'd0);

    // Pointer back at 0: requester 1 wins over 3, then 3 is served.
    @(posedge clk); #1;
    set_req(1, 32'h40A00000, 32'h40000000);
    set_req(3, 32'h3F000000, 32'h40800000);
    serve(1, 32'h40A00000, 32'h40000000, 32'h41200000, 4'b0, 3, 0, 32'h41200000, 5'b00000, 5, 1, 1);
    serve(3, 32'h3F000000, 32'h40800000, 32'h40000000, 4'b0, 2, 0, 32'h40000000, 5'b00000, 4, 1, 1);
    wait_idle();
    repeat (3) @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
